// File: rtl/common_types_pkg.sv
// Shared types and AXI constants used by the boot copier and its bus interface.
package common_types_pkg;

    // Copier control states: one word moves through AR -> R -> AW_W -> B per pass.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } copier_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Every beat is a full 32-bit word.
    localparam logic [2:0] AXSIZE_4B   = 3'b010;

endpackage

// File: rtl/axi_bus_if.sv
// Single-beat AXI bus bundle (32-bit address/data, 4-bit IDs) between a controller and the interconnect mux.
interface axi_bus_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport controller_to_mux (
        output arvalid, araddr, arid, arlen, arsize,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );
endinterface

// File: rtl/axi_boot_copier.sv
// Copies word_count 32-bit words from flash (SRC_BASE) to RAM (DST_BASE), one AXI
// transaction at a time: read a word, write it back out, wait for the write response.
module axi_boot_copier
    import common_types_pkg::*;
#(
    parameter logic [31:0] SRC_BASE = 32'h9000_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_0000,
    parameter logic [3:0]  COPY_ID  = 4'd1
) (
    input  logic                 clk,
    input  logic                 nrst,
    axi_bus_if.controller_to_mux abif,
    input  logic                 start,
    input  logic [15:0]          word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    copier_state_e state_q, state_d;
    logic [31:0]   src_q, src_d;
    logic [31:0]   dst_q, dst_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   hold_q, hold_d;
    logic          error_q, error_d;
    // Record which of the two write-side handshakes already happened in AW_W.
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          aw_fin, w_fin;

    // Response IDs and rlast carry nothing for a single-ID, single-beat master.
    logic          unused_resp_fields;
    assign unused_resp_fields = ^{abif.rid, abif.bid, abif.rlast};

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            error_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            error_q   <= error_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and register updates for the copy sequence.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        idx_d     = idx_q;
        count_d   = count_q;
        hold_d    = hold_q;
        error_d   = error_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_fin    = aw_done_q | abif.awready;
        w_fin     = w_done_q | abif.wready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = word_count;
                    src_d   = SRC_BASE;
                    dst_d   = DST_BASE;
                    idx_d   = '0;
                    error_d = 1'b0;
                    state_d = (word_count == 16'd0) ? ST_DONE : ST_AR;
                end
            end
            ST_AR: begin
                if (abif.arready) state_d = ST_R;
            end
            ST_R: begin
                if (abif.rvalid) begin
                    hold_d = abif.rdata;
                    if (abif.rresp != RESP_OKAY) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_AW_W;
                    end
                end
            end
            ST_AW_W: begin
                // Leave only when both channels have handshaken, in whatever order.
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_B;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            ST_B: begin
                if (abif.bvalid) begin
                    if (abif.bresp != RESP_OKAY) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        src_d   = src_q + 32'd4;
                        dst_d   = dst_q + 32'd4;
                        state_d = (idx_q + 16'd1 == count_q) ? ST_DONE : ST_AR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign error = error_q;

    assign abif.arvalid = (state_q == ST_AR);
    assign abif.araddr  = src_q;
    assign abif.arid    = COPY_ID;
    assign abif.arlen   = 8'd0;
    assign abif.arsize  = AXSIZE_4B;

    assign abif.rready  = (state_q == ST_R);

    assign abif.awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign abif.awaddr  = dst_q;
    assign abif.awid    = COPY_ID;
    assign abif.awlen   = 8'd0;
    assign abif.awsize  = AXSIZE_4B;

    assign abif.wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign abif.wdata   = hold_q;
    assign abif.wstrb   = 4'hF;
    assign abif.wlast   = 1'b1;

    assign abif.bready  = (state_q == ST_B);

endmodule
